// File: rtl/tff_pkg.sv
// Shared types and helpers for the T-flip-flop counter family.
// Command priority encoding and binary-to-Gray conversion.
package tff_pkg;

   // Listed in descending priority; the counter resolves exactly one per edge.
   typedef enum logic [2:0] {
      CMD_PRE  = 3'd0,
      CMD_CLR  = 3'd1,
      CMD_LD   = 3'd2,
      CMD_CNT  = 3'd3,
      CMD_HOLD = 3'd4
   } cmd_e;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/tff_stage.sv
// Single T flip-flop stage: toggles on t, async active-low reset to rst_val.
module tff_stage (
   input  logic clk,
   input  logic clr_n,
   input  logic rst_val,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         q <= rst_val;
      end else if (t) begin
         q <= ~q;
      end
   end

endmodule

// File: rtl/tff_counter.sv
// Modulo up/down counter built from WIDTH tff_stage cells with preset, clear, load and wrap flag.
// Define TFF_COUNTER_GRAY_EN to register a Gray-coded copy of the count on gray.
module tff_counter
   import tff_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MODULUS   = 2 ** WIDTH,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             pre,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             tc,
   output logic             wrap,
   output logic [WIDTH-1:0] gray
);

   localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   cmd_e             cmd;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] t;
   logic             wrap_next;

   always_comb begin
      if (pre)       cmd = CMD_PRE;
      else if (clr)  cmd = CMD_CLR;
      else if (ld)   cmd = CMD_LD;
      else if (en)   cmd = CMD_CNT;
      else           cmd = CMD_HOLD;
   end

   // Out-of-range q (illegal RESET_VAL only) steers back into 0..MAX_Q without a wrap pulse.
   always_comb begin
      q_next    = q;
      wrap_next = 1'b0;
      case (cmd)
         CMD_PRE: q_next = MAX_Q;
         CMD_CLR: q_next = '0;
         CMD_LD:  q_next = ({1'b0, d} >= MOD_EXT) ? MAX_Q : d;
         CMD_CNT: begin
            if (up) begin
               if (q == MAX_Q) begin
                  q_next    = '0;
                  wrap_next = 1'b1;
               end else if (q > MAX_Q) begin
                  q_next = '0;
               end else begin
                  q_next = q + WIDTH'(1);
               end
            end else begin
               if (q == '0) begin
                  q_next    = MAX_Q;
                  wrap_next = 1'b1;
               end else if (q > MAX_Q) begin
                  q_next = MAX_Q;
               end else begin
                  q_next = q - WIDTH'(1);
               end
            end
         end
         default: q_next = q;
      endcase
   end

   // Every command, load included, is applied as a per-bit toggle mask.
   assign t = q ^ q_next;

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      tff_stage u_stage (
         .clk     (clk),
         .clr_n   (clr_n),
         .rst_val (RST_Q[i]),
         .t       (t[i]),
         .q       (q[i])
      );
   end

   assign qn = ~q;
   assign tc = en & ~pre & ~clr & ~ld & ((up & (q == MAX_Q)) | (~up & (q == '0)));

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         wrap <= 1'b0;
      end else begin
         wrap <= wrap_next;
      end
   end

`ifdef TFF_COUNTER_GRAY_EN
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         gray <= WIDTH'(bin2gray(32'(RESET_VAL)));
      end else begin
         gray <= WIDTH'(bin2gray(32'(q_next)));
      end
   end
`else
   assign gray = '0;
`endif

endmodule

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter: modulo-10 main instance plus a modulo-16, RESET_VAL=7 instance.
// Gray expectations follow TFF_COUNTER_GRAY_EN.
module tb_tff_counter;

   typedef struct {
      logic [3:0] q;
      logic       wrap;
   } exp_t;

   logic       clk = 1'b0;
   logic       clr_n;
   logic       pre, clr, ld, en, up;
   logic [3:0] d;
   logic [3:0] q, qn, gray;
   logic       tc, wrap;

   logic       pre7, clr7, ld7, en7, up7;
   logic [3:0] d7;
   logic [3:0] q7, qn7, gray7;
   logic       tc7, wrap7;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   tff_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
      .clk(clk), .clr_n(clr_n), .pre(pre), .clr(clr), .ld(ld), .d(d), .en(en), .up(up),
      .q(q), .qn(qn), .tc(tc), .wrap(wrap), .gray(gray)
   );

   tff_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(7)) dut7 (
      .clk(clk), .clr_n(clr_n), .pre(pre7), .clr(clr7), .ld(ld7), .d(d7), .en(en7), .up(up7),
      .q(q7), .qn(qn7), .tc(tc7), .wrap(wrap7), .gray(gray7)
   );

   function automatic logic [3:0] g(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [3:0] exp_gray(input logic [3:0] b);
`ifdef TFF_COUNTER_GRAY_EN
      return g(b);
`else
      return 4'h0 & b;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   // Drive one command just after a falling edge, check tc before the rising edge,
   // then pop the scoreboard entry and compare the registered outputs.
   task automatic step(input logic p, input logic c, input logic l, input logic [3:0] dd,
                       input logic e, input logic u,
                       input logic [3:0] eq, input logic ew, input logic etc);
      exp_t x;
      pre = p; clr = c; ld = l; d = dd; en = e; up = u;
      sb.push_back('{q: eq, wrap: ew});
      #1;
      chk("tc", {31'd0, tc}, {31'd0, etc});
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk("q", {28'd0, q}, {28'd0, x.q});
      chk("qn", {28'd0, qn}, {28'd0, ~x.q});
      chk("wrap", {31'd0, wrap}, {31'd0, x.wrap});
      chk("gray", {28'd0, gray}, {28'd0, exp_gray(x.q)});
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] prev_g;
      logic [3:0] diff;
      logic [3:0] e7;
      pre = 0; clr = 0; ld = 0; d = 0; en = 0; up = 1;
      pre7 = 0; clr7 = 0; ld7 = 0; d7 = 0; en7 = 0; up7 = 1;
      clr_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_q", {28'd0, q}, 32'd0);
      chk("rst_qn", {28'd0, qn}, 32'hF);
      chk("rst_wrap", {31'd0, wrap}, 32'd0);
      chk("rst_gray", {28'd0, gray}, 32'd0);
      chk("rst7_q", {28'd0, q7}, 32'd7);
      chk("rst7_gray", {28'd0, gray7}, {28'd0, exp_gray(4'd7)});
      clr_n = 1'b1;

      // Up count through the modulo-10 wrap.
      for (int i = 1; i <= 12; i++)
         step(0, 0, 0, 4'd0, 1, 1, 4'(i % 10), i == 10, i == 10);

      // Clear, then count down through 0 -> 9 twice.
      step(0, 1, 0, 4'd0, 1, 0, 4'd0, 0, 0);
      for (int i = 1; i <= 12; i++)
         step(0, 0, 0, 4'd0, 1, 0, 4'((10 - (i % 10)) % 10), (i == 1) || (i == 11),
              (i == 1) || (i == 11));

      // Priority: pre beats everything, then clr beats ld.
      step(1, 1, 1, 4'd3, 1, 1, 4'd9, 0, 0);
      step(0, 1, 1, 4'd3, 1, 1, 4'd0, 0, 0);

      // Load saturation and load suppressing tc at q == MODULUS-1.
      step(0, 0, 1, 4'hC, 1, 1, 4'd9, 0, 0);
      step(0, 0, 1, 4'd5, 1, 1, 4'd5, 0, 0);
      step(0, 0, 0, 4'd0, 0, 1, 4'd5, 0, 0);
      step(0, 0, 0, 4'd0, 1, 1, 4'd6, 0, 0);

      // Async reset between edges takes effect immediately.
      #2;
      clr_n = 1'b0;
      en = 1'b1;
      #1;
      chk("async_q", {28'd0, q}, 32'd0);
      chk("async_wrap", {31'd0, wrap}, 32'd0);
      chk("async7_q", {28'd0, q7}, 32'd7);
      @(negedge clk);
      chk("held_q", {28'd0, q}, 32'd0);
      clr_n = 1'b1;
      step(0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0);

      // 32 up counts on the modulo-16 instance, starting from its reset value 7.
      prev_g = gray7;
      en7 = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         @(posedge clk);
         #1;
         e7 = 4'((7 + i) % 16);
         chk("q7", {28'd0, q7}, {28'd0, e7});
         chk("wrap7", {31'd0, wrap7}, {31'd0, e7 == 4'd0});
         chk("gray7", {28'd0, gray7}, {28'd0, exp_gray(e7)});
`ifdef TFF_COUNTER_GRAY_EN
         diff = gray7 ^ prev_g;
         chk("gray7_adj", $countones(diff), 32'd1);
`else
         diff = 4'h0;
`endif
         prev_g = gray7;
      end
      en7 = 1'b0;
      if (diff != 4'h0 && diff == 4'h0) $display("unreachable");

      if (sb.size() != 0) begin
         total++;
         $error("FAIL scoreboard_left observed=%0d expected=0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
